// File: rtl/load_store_unit.sv
// Load/store alignment stage: extracts and extends sub-word loads, flags misaligned
// accesses and performs sub-word stores as a read-modify-write on a word-write memory.
module load_store_unit #(
    parameter bit MISALIGN_CHK = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] Load_Data,
    output logic        Stall,
    output logic        Misaligned,
    output logic [31:0] Mem_Addr,
    output logic [31:0] Mem_WData,
    output logic        Mem_WE,
    input  logic [31:0] Mem_RData
);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] MERGE_WR = 1'b1;

    logic [0:0]  state;
    logic [29:0] m_word_addr;
    logic        m_is_half;
    logic [1:0]  m_lane;
    logic [15:0] m_wdata;
    logic [31:0] m_rdata;

    logic        is_store;
    logic        is_load;
    logic        store_ok;
    logic        load_ok;
    logic        misaligned_raw;
    logic        sub_store;
    logic        word_store;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;
    logic [31:0] merged;

    // Decode of the live access; stores win when both strobes are high.
    always_comb begin
        is_store = MemWrite;
        is_load  = MemRead & ~MemWrite;
        store_ok = is_store && (Funct3 == 3'b000 || Funct3 == 3'b001 || Funct3 == 3'b010);
        load_ok  = is_load  && (Funct3 == 3'b000 || Funct3 == 3'b001 || Funct3 == 3'b010 ||
                                Funct3 == 3'b100 || Funct3 == 3'b101);
        misaligned_raw = MISALIGN_CHK && (store_ok || load_ok) &&
                         ((Funct3[1:0] == 2'b01 && ALUResult[0]) ||
                          (Funct3[1:0] == 2'b10 && ALUResult[1:0] != 2'b00));
        sub_store  = store_ok && !misaligned_raw && (Funct3[1:0] != 2'b10);
        word_store = store_ok && !misaligned_raw && (Funct3[1:0] == 2'b10);
    end

    always_comb begin
        case (ALUResult[1:0])
            2'b00:   load_byte = Mem_RData[7:0];
            2'b01:   load_byte = Mem_RData[15:8];
            2'b10:   load_byte = Mem_RData[23:16];
            default: load_byte = Mem_RData[31:24];
        endcase
        load_half = ALUResult[1] ? Mem_RData[31:16] : Mem_RData[15:0];
        case (Funct3)
            3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_ext = {24'h000000, load_byte};
            3'b001:  load_ext = {{16{load_half[15]}}, load_half};
            3'b101:  load_ext = {16'h0000, load_half};
            default: load_ext = Mem_RData;
        endcase
    end

    // The captured word with only the target lane replaced by the store data.
    always_comb begin
        merged = m_rdata;
        if (m_is_half) begin
            if (m_lane[1]) merged[31:16] = m_wdata;
            else           merged[15:0]  = m_wdata;
        end else begin
            case (m_lane)
                2'b00:   merged[7:0]   = m_wdata[7:0];
                2'b01:   merged[15:8]  = m_wdata[7:0];
                2'b10:   merged[23:16] = m_wdata[7:0];
                default: merged[31:24] = m_wdata[7:0];
            endcase
        end
    end

    always_comb begin
        Load_Data  = (state == IDLE && load_ok && !misaligned_raw) ? load_ext : 32'h0;
        Mem_Addr   = (state == MERGE_WR) ? {m_word_addr, 2'b00} : {ALUResult[31:2], 2'b00};
        Mem_WData  = (state == MERGE_WR) ? merged : WriteData;
        Mem_WE     = ~RST & ((state == MERGE_WR) | (state == IDLE & word_store));
        Stall      = ~RST & (state == IDLE) & sub_store;
        Misaligned = ~RST & (state == IDLE) & misaligned_raw;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            m_word_addr <= '0;
            m_is_half   <= 1'b0;
            m_lane      <= '0;
            m_wdata     <= '0;
            m_rdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sub_store) begin
                        m_word_addr <= ALUResult[31:2];
                        m_is_half   <= Funct3[0];
                        m_lane      <= ALUResult[1:0];
                        m_wdata     <= WriteData[15:0];
                        m_rdata     <= Mem_RData;
                        state       <= MERGE_WR;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store alignment stage between the ALU result path and `Mem_Datos`. It turns core byte, halfword and word loads/stores (RV32I `Funct3` encoding) into word-wide accesses on the single-port, word-write `Mem_Datos`. Loads are extracted and sign/zero-extended, misaligned accesses are flagged, and sub-word stores are done as a two-cycle read-modify-write that stalls the core for one cycle.

## Interface
- `MISALIGN_CHK`, default 1: 1 = detect misaligned halfword/word accesses and suppress them; 0 = ignore the low address bits (use the halfword or word lane the address falls in).

- `CLK` input 1: clock; all state updates on the rising edge.
- `RST` input 1: reset, synchronous and active-high.
- `MemRead` input 1: a load is in progress this cycle.
- `MemWrite` input 1: a store is in progress this cycle; it has priority if both are high.
- `Funct3` input 3: 000 B, 001 H, 010 W, 100 BU, 101 HU; stores use only 000/001/010.
- `ALUResult` input 32: byte address.
- `WriteData` input 32: store data from rs2.
- `Load_Data` output 32: extended load result; combinational.
- `Stall` output 1: core must hold PC and all inputs stable next cycle.
- `Misaligned` output 1: one-cycle flag that the access was suppressed.
- `Mem_Addr` output 32: to `Mem_Datos.ALUResult`; `{addr[31:2],2'b00}`.
- `Mem_WData` output 32: to `Mem_Datos.WriteData`.
- `Mem_WE` output 1: to `Mem_Datos.Write_EN`.
- `Mem_RData` input 32: from `Mem_Datos.Read_Data`. The read is asynchronous; the write commits on the rising `CLK`.

## Operation
**FSM states**
- `IDLE`: normal single-cycle operation.
- `MERGE_WR`: second cycle of a sub-word store.

**In `IDLE`**
- Live inputs drive `Mem_Addr`.
- LW/LB/LH/LBU/LHU:
  - Lane select is `addr[1:0]` for bytes and `addr[1]` for halfwords.
  - B/H sign-extend the lane; BU/HU zero-extend it; W passes the word through.
  - No stall.
- SW: `Mem_WE`=1 and `Mem_WData`=`WriteData` in the same cycle; no stall.
- SB/SH:
  - `Stall`=1 and `Mem_WE`=0.
  - At the clock edge, capture the word address, `Funct3`, lane bits, `WriteData` and `Mem_RData` into merge registers, then go to `MERGE_WR`.

**In `MERGE_WR`**
- Drive from the captured registers only; live inputs are ignored.
- `Mem_WE`=1 and `Stall`=0.
- `Mem_WData` is the captured word with the target lane replaced:
  - SB: `WriteData[7:0]` into byte lane `addr[1:0]`.
  - SH: `WriteData[15:0]` into half lane `addr[1]`.
- Always return to `IDLE` on the next edge.

**Misaligned access** (`MISALIGN_CHK`=1)
- Condition: H/HU/SH with `addr[0]`=1, or W/SW with `addr[1:0]`≠0.
- Response, in the same cycle: `Misaligned`=1, `Mem_WE`=0, `Load_Data`=0, `Stall`=0, no state change.

**Unsupported `Funct3`**
- Applies to loads with 011/110/111 and stores with ≥011.
- Treated as a no-op: `Load_Data`=0, `Mem_WE`=0, `Misaligned`=0.

**No access** (`MemRead`=`MemWrite`=0): `Load_Data`=0, `Mem_WE`=0.

## Timing
**Reset**
- State → `IDLE`; merge registers → 0.
- `Stall`, `Misaligned` and `Mem_WE` are 0 in every cycle `RST`=1.
- `Mem_WE` is gated by `~RST` combinationally, so no write lands in any reset cycle, including mid-`MERGE_WR`.

**Latency**
- Loads: 0 cycles; `Load_Data` is valid in the same cycle as the address.
- SW: 1 cycle.
- SB/SH: 2 cycles; `Stall` is high for exactly 1 cycle and the write commits at the end of cycle 2.

**Ordering**
- Back-to-back SB/SH: `IDLE`→`MERGE_WR`→`IDLE`→`MERGE_WR`; each costs 2 cycles.
- A load in the cycle after `MERGE_WR` sees the merged word, because the write has committed and the memory read is asynchronous.
- The core holds its inputs while `Stall`=1; the block does not rely on this in `MERGE_WR`.

**Arithmetic**: all widths are 32-bit; extension is by replicating bit 7 or bit 15.

## Test plan
Word 0x10 is preloaded with 0x11223344.
1. **Loads**:
   - LB 0x13 → `Load_Data`=0x00000011.
   - Reload 0x10 with 0x8899AABB: LB 0x10 → 0xFFFFFFBB; LBU 0x10 → 0x000000BB; LH 0x12 → 0xFFFF8899; LHU 0x12 → 0x00008899.
   - In all cases `Stall`=0.
2. **SB with read-modify-write**:
   - SB 0x11 with data 0xFFFFFFA5 → cycle 1: `Stall`=1, `Mem_WE`=0.
   - Cycle 2: `Mem_WE`=1, `Mem_WData`=0x1122A544.
   - LW 0x10 in the next cycle → 0x1122A544.
3. **SH and SW**:
   - SH 0x12 with 0x0000BEEF → word becomes 0xBEEF3344 after 2 cycles.
   - SW 0x14 with 0xDEADBEEF → 1-cycle write, `Stall` never high.
4. **Misaligned**:
   - LW 0x12 → `Misaligned`=1, `Load_Data`=0.
   - SH 0x13 → `Misaligned`=1, `Mem_WE`=0 in every cycle, memory unchanged.
   - With `MISALIGN_CHK`=0, LW 0x12 returns word 0x10.
5. **Reset mid-operation**: SB 0x10, then `RST`=1 during `MERGE_WR` → `Mem_WE`=0, memory unchanged, next cycle `IDLE` with `Stall`=0.
6. **Back-to-back**: SB 0x10 (0xAA) then SB 0x11 (0xBB) → word 0x1122BBAA, 4 cycles total, 2 stall cycles.
